// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Drives one shared BCD decoder, with a per-slot anode guard, leading-zero blanking and frame-aligned updates.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int GUARD      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    blank_lz,
    output logic [3:0]              dig_code,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start,
    output logic                    pend
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_OFF, ST_GUARD, ST_DRIVE} state_t;

    state_t                  state, nxt_state;
    logic [CW-1:0]           cnt, nxt_cnt;
    logic [IW-1:0]           idx, nxt_idx;
    logic [4*NUM_DIGITS-1:0] disp_reg, pend_reg, nxt_disp;
    logic                    boundary, xfer;
    logic [3:0]              nxt_code;
    logic [NUM_DIGITS-1:0]   nxt_an_n;
    logic                    nxt_fs;

    // Outputs are registered from the next-cycle slot position, so each
    // output cycle matches the cnt/idx held in that same cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            cnt         <= '0;
            idx         <= '0;
            dig_code    <= 4'hF;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            idx         <= nxt_idx;
            dig_code    <= nxt_code;
            an_n        <= nxt_an_n;
            frame_start <= nxt_fs;
        end
    end

    // NOTE: the double buffers are plain flops, not RAM, so they are reset to
    // give a defined blank display and no stale pending value after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg <= '0;
            pend_reg <= '0;
            pend     <= 1'b0;
        end else begin
            if (xfer) disp_reg <= pend_reg;
            if (load) begin
                pend_reg <= bcd_in;
                pend     <= 1'b1;
            end else if (xfer) begin
                pend     <= 1'b0;
            end
        end
    end

    // A boundary is the wrap out of the last digit, or the first enabled
    // cycle after being dark.
    // NOTE: every comb output gets a default first, so no path infers a latch.
    always_comb begin
        nxt_cnt   = '0;
        nxt_idx   = '0;
        boundary  = 1'b0;
        nxt_state = ST_OFF;
        if (enable) begin
            if (state == ST_OFF) begin
                boundary = 1'b1;
            end else if (cnt == CNT_LAST) begin
                if (idx == IDX_LAST) boundary = 1'b1;
                else                 nxt_idx  = idx + IW'(1);
            end else begin
                nxt_cnt = cnt + CW'(1);
                nxt_idx = idx;
            end
            nxt_state = (nxt_cnt < GUARD_CNT) ? ST_GUARD : ST_DRIVE;
        end
        xfer     = boundary && pend;
        nxt_disp = xfer ? pend_reg : disp_reg;
    end

    always_comb begin
        logic [3:0] nib;
        logic       blank;
        nib      = 4'h0;
        blank    = blank_lz && (nxt_idx != '0);
        nxt_code = 4'hF;
        nxt_an_n = '1;
        nxt_fs   = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (IW'(d) == nxt_idx) nib = nxt_disp[4*d +: 4];
            if (IW'(d) >= nxt_idx && nxt_disp[4*d +: 4] != 4'h0) blank = 1'b0;
        end
        if (nxt_state != ST_OFF) begin
            nxt_code = blank ? 4'hF : nib;
            nxt_fs   = boundary;
            if (nxt_state == ST_DRIVE) nxt_an_n[nxt_idx] = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
// Stimulus pushes hand-derived per-cycle expectations; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dig_code;
    logic [3:0]  an_n;
    logic        frame_start;
    logic        pend;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(8), .GUARD(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .bcd_in      (bcd_in),
        .blank_lz    (blank_lz),
        .dig_code    (dig_code),
        .an_n        (an_n),
        .frame_start (frame_start),
        .pend        (pend)
    );

    typedef struct {
        logic [3:0] an_n;
        logic [3:0] code;
        logic       fs;
        logic       pend;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_push   = 0;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got an_n,code,fs,pend=%b_%h_%b_%b required %b_%h_%b_%b",
                     name, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("entry%0d", e.tag), {an_n, dig_code, frame_start, pend},
                      {e.an_n, e.code, e.fs, e.pend});
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [3:0] c, input logic f, input logic p);
        sb.push_back('{a, c, f, p, n_push});
        n_push++;
    endtask

    // Inputs set just after a negedge are sampled at the next posedge; the
    // entry pushed now describes the cycle that follows that edge.
    task automatic step(input logic en, input logic ld, input logic [15:0] val);
        @(negedge clk);
        #1;
        enable = en;
        load   = ld;
        bcd_in = val;
    endtask

    task automatic dark(input logic ld, input logic [15:0] val, input logic p);
        step(1'b0, ld, val);
        push(4'hF, 4'hF, 1'b0, p);
    endtask

    // codes = expected decoder nibbles, digit 3 in [15:12] down to digit 0 in [3:0].
    task automatic run_frame(input logic [15:0] codes, input logic blz, input int ncyc,
                             input int lc1, input logic [15:0] lv1,
                             input int lc2, input logic [15:0] lv2);
        logic       p;
        logic       ld;
        logic [3:0] a;
        p = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            ld = (i == lc1) || (i == lc2);
            step(1'b1, ld, (i == lc2) ? lv2 : lv1);
            if (i == 0) blank_lz = blz;
            if (ld) p = 1'b1;
            a = ((i % 8) < 2) ? 4'b1111 : ~(4'b0001 << (i / 8));
            push(a, codes[(i / 8) * 4 +: 4], i == 0, p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        dark(1'b0, 16'h0000, 1'b0);
        dark(1'b1, 16'h1234, 1'b1);
        // Run into idx 1 DRIVE with a pending load, then reset asynchronously.
        run_frame(16'h1234, 1'b0, 12, 5, 16'h5555, -1, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        push(4'hF, 4'hF, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        step(1'b0, 1'b0, 16'h0);
        rst_n = 1'b1;
        push(4'hF, 4'hF, 1'b0, 1'b0);

        dark(1'b1, 16'h1234, 1'b1);
        run_frame(16'h1234, 1'b0, 32, -1, 16'h0, -1, 16'h0);
        run_frame(16'h1234, 1'b0, 32, 31, 16'h0050, -1, 16'h0);
        run_frame(16'hFF50, 1'b1, 32, 31, 16'h0000, -1, 16'h0);
        run_frame(16'hFFF0, 1'b1, 32, 31, 16'h0050, -1, 16'h0);
        run_frame(16'h0050, 1'b0, 32, 31, 16'h1000, -1, 16'h0);
        run_frame(16'h1000, 1'b1, 32, 16, 16'h9999, -1, 16'h0);
        run_frame(16'h9999, 1'b1, 32, 5, 16'h1111, 20, 16'h2222);
        run_frame(16'h2222, 1'b1, 32, 10, 16'h3333, -1, 16'h0);
        run_frame(16'h3333, 1'b1, 32, 0, 16'h4444, -1, 16'h0);
        // Stop after idx 1 cnt 5, then go dark and load while disabled.
        run_frame(16'h4444, 1'b1, 14, -1, 16'h0, -1, 16'h0);
        dark(1'b0, 16'h0000, 1'b0);
        dark(1'b1, 16'h5678, 1'b1);
        dark(1'b0, 16'h0000, 1'b1);
        run_frame(16'h5678, 1'b0, 32, -1, 16'h0, -1, 16'h0);
        dark(1'b0, 16'h0000, 1'b0);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
